// File: rtl/svm_detect.sv
// svm_detect: bias/threshold detection stage behind the SVM window scorer.
// Define SVM_DETECT_HSUPPRESS_EN for horizontal non-maximum suppression.
module svm_detect #(
  parameter int WPI        = 40,
  parameter int HPI        = 20,
  parameter int FIFO_DEPTH = 16,
  parameter int COORD_W    = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_fv,
  input  logic        in_dv,
  input  logic [31:0] in_data,
  output logic        out_fv,
  output logic        out_dv,
  output logic [7:0]  out_data,
  input  logic [2:0]  addr_rel_i,
  input  logic        wr_i,
  input  logic        rd_i,
  input  logic [31:0] datawr_i,
  output logic [31:0] datard_o,
  output logic        irq_o
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = 2 * COORD_W;
  localparam logic [COORD_W-1:0] XMAX = COORD_W'(WPI - 1);
  localparam logic [COORD_W-1:0] YMAX = COORD_W'(HPI - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);
`ifdef SVM_DETECT_HSUPPRESS_EN
  localparam logic signed [31:0] SMIN = 32'sh8000_0000;
`endif

  logic               scr_en;
  logic               scr_ie;
  logic signed [31:0] bias;
  logic signed [31:0] thresh;

  logic               fv_q;
  logic [COORD_W-1:0] x;
  logic [COORD_W-1:0] y;
  logic               rise;
  logic [COORD_W-1:0] cur_x;
  logic [COORD_W-1:0] cur_y;

  logic signed [32:0] sum33;
  logic signed [31:0] sat_sum;

  logic               s1_valid;
  logic               s1_fv;
  logic signed [31:0] s1_sum;
  logic [COORD_W-1:0] s1_x;
  logic [COORD_W-1:0] s1_y;

  logic               pass;
  logic               dv_n;
  logic               det_n;
  logic [COORD_W-1:0] dx_n;
  logic [COORD_W-1:0] dy_n;
  logic               fv_src;

  logic               push_q;
  logic [COORD_W-1:0] push_x;
  logic [COORD_W-1:0] push_y;
  logic [7:0]         frame_cnt;
  logic [7:0]         cnt_inc;
  logic [7:0]         last_cnt;

  logic [EW-1:0]      mem [FIFO_DEPTH];
  logic [AW-1:0]      wp;
  logic [AW-1:0]      rp;
  logic [CW-1:0]      count;
  logic               ovf;
  logic               empty;
  logic               full;
  logic               clr;
  logic               pop;
  logic               push_ok;
  logic [31:0]        rdata;

  assign empty   = (count == '0);
  assign full    = (count == FULL_CNT);
  assign clr     = wr_i && (addr_rel_i == 3'd0) && datawr_i[1];
  assign pop     = rd_i && (addr_rel_i == 3'd3) && !empty;
  assign push_ok = push_q && (!full || pop);
  assign irq_o   = scr_ie && !empty;

  always_ff @(posedge clk) begin
    if (reset) begin
      scr_en <= 1'b0;
      scr_ie <= 1'b0;
      bias   <= '0;
      thresh <= '0;
    end else if (wr_i) begin
      unique case (1'b1)
        (addr_rel_i == 3'd0): begin
          scr_en <= datawr_i[0];
          scr_ie <= datawr_i[2];
        end
        (addr_rel_i == 3'd1): bias   <= datawr_i;
        (addr_rel_i == 3'd2): thresh <= datawr_i;
        default: ;
      endcase
    end
  end

  // A sample arriving on the frame's first cycle already sees x=y=0.
  assign rise  = in_fv && !fv_q;
  assign cur_x = rise ? '0 : x;
  assign cur_y = rise ? '0 : y;

  always_ff @(posedge clk) begin
    if (reset) begin
      fv_q <= 1'b0;
      x    <= '0;
      y    <= '0;
    end else begin
      fv_q <= in_fv;
      if (in_dv) begin
        if (cur_x == XMAX) begin
          x <= '0;
          y <= (cur_y == YMAX) ? cur_y : cur_y + 1'b1;
        end else begin
          x <= cur_x + 1'b1;
          y <= cur_y;
        end
      end else if (rise) begin
        x <= '0;
        y <= '0;
      end
    end
  end

  always_comb begin
    sum33 = {in_data[31], in_data} + {bias[31], bias};
    if (sum33[32] != sum33[31])
      sat_sum = sum33[32] ? 32'sh8000_0000 : 32'sh7FFF_FFFF;
    else
      sat_sum = sum33[31:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_fv    <= 1'b0;
      s1_sum   <= '0;
      s1_x     <= '0;
      s1_y     <= '0;
    end else begin
      s1_valid <= in_dv;
      s1_fv    <= in_fv;
      if (in_dv) begin
        s1_sum <= sat_sum;
        s1_x   <= cur_x;
        s1_y   <= cur_y;
      end
    end
  end

  assign pass = scr_en && (s1_sum > thresh);

`ifdef SVM_DETECT_HSUPPRESS_EN
  logic               h_valid;
  logic               h_pass;
  logic signed [31:0] h_sum;
  logic signed [31:0] h_left;
  logic [COORD_W-1:0] h_x;
  logic [COORD_W-1:0] h_y;
  logic               fv_d2;
  logic               dec;
  logic signed [31:0] right;

  // Held window is decided once its right neighbour is known.
  assign dec   = h_valid && (s1_valid || (h_x == XMAX));
  assign right = (h_x == XMAX) ? SMIN : s1_sum;

  always_comb begin
    dv_n   = dec;
    det_n  = dec && h_pass && (h_sum >= h_left) && (h_sum > right);
    dx_n   = h_x;
    dy_n   = h_y;
    fv_src = fv_d2;
  end

  // Frame flag gets the extra stage so the last column stays inside it.
  always_ff @(posedge clk) begin
    if (reset) begin
      h_valid <= 1'b0;
      h_pass  <= 1'b0;
      h_sum   <= '0;
      h_left  <= '0;
      h_x     <= '0;
      h_y     <= '0;
      fv_d2   <= 1'b0;
    end else begin
      fv_d2 <= s1_fv;
      if (s1_valid) begin
        h_valid <= 1'b1;
        h_pass  <= pass;
        h_sum   <= s1_sum;
        h_left  <= (s1_x == '0) ? SMIN : h_sum;
        h_x     <= s1_x;
        h_y     <= s1_y;
      end else if (dec) begin
        h_valid <= 1'b0;
      end
    end
  end
`else
  always_comb begin
    dv_n   = s1_valid;
    det_n  = s1_valid && pass;
    dx_n   = s1_x;
    dy_n   = s1_y;
    fv_src = s1_fv;
  end
`endif

  assign cnt_inc = (det_n && frame_cnt != 8'hFF) ? frame_cnt + 8'd1 : frame_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      out_dv    <= 1'b0;
      out_fv    <= 1'b0;
      out_data  <= '0;
      push_q    <= 1'b0;
      push_x    <= '0;
      push_y    <= '0;
      frame_cnt <= '0;
      last_cnt  <= '0;
    end else begin
      out_dv   <= dv_n;
      out_fv   <= fv_src;
      out_data <= det_n ? 8'hFF : 8'h00;
      push_q   <= det_n;
      push_x   <= dx_n;
      push_y   <= dy_n;
      if (rise)
        frame_cnt <= '0;
      else
        frame_cnt <= cnt_inc;
      if (out_fv && !fv_src)
        last_cnt <= cnt_inc;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok && !clr)
      mem[wp] <= {push_y, push_x};
  end

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
      ovf   <= 1'b0;
    end else begin
      if (push_ok)
        wp <= wp + 1'b1;
      if (pop)
        rp <= rp + 1'b1;
      if (push_q && !push_ok)
        ovf <= 1'b1;
      count <= count + CW'(push_ok) - CW'(pop);
    end
  end

  always_comb begin
    rdata = '0;
    unique case (1'b1)
      (addr_rel_i == 3'd0): rdata = {29'd0, scr_ie, 1'b0, scr_en};
      (addr_rel_i == 3'd1): rdata = bias;
      (addr_rel_i == 3'd2): rdata = thresh;
      (addr_rel_i == 3'd3): rdata = empty ? '0 : 32'(mem[rp]);
      (addr_rel_i == 3'd4):
        rdata = {last_cnt, 5'd0, ovf, full, empty, 16'(count)};
      default: rdata = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset)
      datard_o <= '0;
    else if (rd_i)
      datard_o <= rdata;
  end

endmodule

// File: tb/tb_svm_detect.sv
// tb_svm_detect: scoreboard bench for svm_detect (default build).
// Map bytes queued at drive time; FIFO/STATUS checked against a model.
module tb_svm_detect;

  localparam int WPI = 40;
  localparam int HPI = 20;
  localparam int DEPTH = 16;
  localparam int CWD = 10;
  localparam longint SMAX = 64'sd2147483647;
  localparam longint SMIN = -64'sd2147483648;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_fv, in_dv;
  logic [31:0] in_data;
  logic        out_fv, out_dv;
  logic [7:0]  out_data;
  logic [2:0]  addr_rel_i;
  logic        wr_i, rd_i;
  logic [31:0] datawr_i;
  logic [31:0] datard_o;
  logic        irq_o;

  svm_detect #(.WPI(WPI), .HPI(HPI), .FIFO_DEPTH(DEPTH), .COORD_W(CWD)) dut (
    .clk(clk), .reset(reset),
    .in_fv(in_fv), .in_dv(in_dv), .in_data(in_data),
    .out_fv(out_fv), .out_dv(out_dv), .out_data(out_data),
    .addr_rel_i(addr_rel_i), .wr_i(wr_i), .rd_i(rd_i),
    .datawr_i(datawr_i), .datard_o(datard_o), .irq_o(irq_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad = 0;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  typedef struct {
    int         cyc;
    logic [7:0] data;
  } exp_t;
  exp_t sbq[$];

  always @(negedge clk) begin : mon
    exp_t e;
    if (!reset && out_dv) begin
      if (sbq.size() == 0) begin
        chk("sb_extra", 64'(out_dv), 64'd0);
      end else begin
        e = sbq.pop_front();
        chk("map_data", 64'(out_data), 64'(e.data));
        chk("map_lat", 64'(cyc), 64'(e.cyc));
      end
    end
  end

  int          mx, my, mframe;
  logic [31:0] mbias, mthr;
  logic        men, movf;
  logic [31:0] mfifo[$];

  function automatic logic model_det(input logic [31:0] s);
    longint t;
    t = longint'($signed(s)) + longint'($signed(mbias));
    if (t > SMAX) t = SMAX;
    if (t < SMIN) t = SMIN;
    return men && (t > longint'($signed(mthr)));
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] s);
    logic d;
    exp_t e;
    d = model_det(s);
    in_dv = 1'b1;
    in_data = s;
    e.cyc = cyc + 2;
    e.data = d ? 8'hFF : 8'h00;
    sbq.push_back(e);
    if (d) begin
      mframe++;
      if (mfifo.size() == DEPTH) movf = 1'b1;
      else mfifo.push_back(32'({my[CWD-1:0], mx[CWD-1:0]}));
    end
    if (mx == WPI - 1) begin
      mx = 0;
      if (my != HPI - 1) my++;
    end else begin
      mx++;
    end
    tick();
    in_dv = 1'b0;
  endtask

  task automatic frame_begin();
    in_fv = 1'b1;
    mx = 0;
    my = 0;
    mframe = 0;
    tick();
  endtask

  task automatic frame_end();
    in_fv = 1'b0;
    repeat (5) tick();
  endtask

  task automatic reg_wr(input logic [2:0] a, input logic [31:0] d);
    addr_rel_i = a;
    datawr_i = d;
    wr_i = 1'b1;
    tick();
    wr_i = 1'b0;
  endtask

  task automatic reg_rd(input logic [2:0] a, output logic [31:0] d);
    addr_rel_i = a;
    rd_i = 1'b1;
    tick();
    rd_i = 1'b0;
    d = datard_o;
  endtask

  task automatic fifo_chk(input string tag);
    logic [31:0] d;
    reg_rd(3'd3, d);
    if (mfifo.size() == 0) chk(tag, 64'(d), 64'd0);
    else chk(tag, 64'(d), 64'(mfifo.pop_front()));
  endtask

  task automatic status_chk(input string tag);
    logic [31:0] d;
    logic [18:0] e;
    reg_rd(3'd4, d);
    e = {movf, mfifo.size() == DEPTH, mfifo.size() == 0, 16'(mfifo.size())};
    chk(tag, 64'(d[18:0]), 64'(e));
  endtask

  task automatic clear_fifo();
    reg_wr(3'd0, {29'd0, 1'b0, 1'b1, men});
    mfifo.delete();
    movf = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    logic [31:0] d;
    logic [31:0] e0;
    reset = 1'b1;
    in_fv = 0; in_dv = 0; in_data = 0;
    addr_rel_i = 0; wr_i = 0; rd_i = 0; datawr_i = 0;
    mx = 0; my = 0; mframe = 0;
    mbias = 0; mthr = 0; men = 0; movf = 0;
    repeat (3) tick();
    chk("rst_out_dv", 64'(out_dv), 64'd0);
    chk("rst_out_fv", 64'(out_fv), 64'd0);
    chk("rst_out_data", 64'(out_data), 64'd0);
    chk("rst_datard", 64'(datard_o), 64'd0);
    chk("rst_irq", 64'(irq_o), 64'd0);
    reset = 1'b0;
    tick();
    reg_rd(3'd4, d);
    chk("rst_status", 64'(d), 64'h0001_0000);
    reg_wr(3'd5, 32'hFFFF_FFFF);
    reg_rd(3'd5, d);
    chk("unmapped_rd", 64'(d), 64'd0);

    // single detection at x=5, 100 against 100 is not a hit
    reg_wr(3'd0, 32'd1); men = 1'b1;
    reg_wr(3'd1, 32'd0); mbias = 0;
    reg_wr(3'd2, 32'd100); mthr = 100;
    reg_rd(3'd2, d);
    chk("thresh_rd", 64'(d), 64'd100);
    frame_begin();
    for (int i = 0; i < WPI; i++)
      send(i == 5 ? 32'd101 : (i == 6 ? 32'd100 : 32'd0));
    frame_end();
    status_chk("t1_status");
    reg_rd(3'd4, d);
    chk("t1_frame_cnt", 64'(d[31:24]), 64'(mframe));
    fifo_chk("t1_fifo0");
    fifo_chk("t1_fifo_empty");

    // saturation at both ends
    frame_begin();
    reg_wr(3'd1, 32'h7FFF_FFFF); mbias = 32'h7FFF_FFFF;
    reg_wr(3'd2, 32'h7FFF_FFFE); mthr = 32'h7FFF_FFFE;
    send(32'h7FFF_FFFF);
    reg_wr(3'd1, 32'hFFFF_FFFF); mbias = 32'hFFFF_FFFF;
    reg_wr(3'd2, 32'h8000_0000); mthr = 32'h8000_0000;
    send(32'h8000_0000);
    frame_end();
    status_chk("t2_status");
    fifo_chk("t2_fifo0");
    fifo_chk("t2_fifo_empty");

    // overflow: 20 hits into 16 entries
    clear_fifo();
    reg_wr(3'd1, 32'd0); mbias = 0;
    reg_wr(3'd2, 32'd0); mthr = 0;
    frame_begin();
    for (int i = 0; i < 20; i++) send(32'd1);
    frame_end();
    status_chk("t3_status_full");
    reg_wr(3'd0, 32'd5);
    reg_rd(3'd0, d);
    chk("scr_rd", 64'(d), 64'd5);
    chk("t3_irq_on", 64'(irq_o), 64'd1);
    for (int i = 0; i < DEPTH; i++) fifo_chk("t3_fifo");
    fifo_chk("t3_fifo_17th");
    chk("t3_irq_off", 64'(irq_o), 64'd0);
    status_chk("t3_status_ovf");
    clear_fifo();
    status_chk("t3_status_clr");

    // full FIFO with push and pop on the same edge
    frame_begin();
    for (int i = 0; i < DEPTH; i++) send(32'd1);
    repeat (4) tick();
    status_chk("t4_status_full");
    e0 = mfifo.pop_front();
    send(32'd1);
    tick();
    addr_rel_i = 3'd3;
    rd_i = 1'b1;
    tick();
    rd_i = 1'b0;
    chk("t4_pop_oldest", 64'(datard_o), 64'(e0));
    frame_end();
    status_chk("t4_status_after");
    clear_fifo();

    // row boundary: (39,0) then (0,1)
    reg_wr(3'd2, 32'd100); mthr = 100;
    frame_begin();
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < WPI; c++)
        send(((r == 0 && c == WPI - 1) || (r == 1 && c == 0)) ? 32'd200 : 32'd0);
    frame_end();
    reg_rd(3'd4, d);
    chk("t5_frame_cnt", 64'(d[31:24]), 64'(mframe));
    status_chk("t5_status");
    fifo_chk("t5_fifo0");
    fifo_chk("t5_fifo1");

    // enable low: map all zero, nothing queued
    reg_wr(3'd0, 32'd0); men = 1'b0;
    frame_begin();
    for (int i = 0; i < 10; i++) send(32'd1000);
    frame_end();
    status_chk("t6_status");

    // reset mid-row
    reg_wr(3'd0, 32'd1); men = 1'b1;
    frame_begin();
    for (int i = 0; i < 3; i++) send(32'd200);
    reset = 1'b1;
    in_fv = 1'b0;
    tick();
    sbq.delete();
    mfifo.delete();
    movf = 0; men = 0; mbias = 0; mthr = 0;
    chk("t7_out_dv", 64'(out_dv), 64'd0);
    chk("t7_out_fv", 64'(out_fv), 64'd0);
    chk("t7_out_data", 64'(out_data), 64'd0);
    chk("t7_datard", 64'(datard_o), 64'd0);
    reset = 1'b0;
    repeat (3) tick();
    chk("t7_out_dv_idle", 64'(out_dv), 64'd0);
    reg_rd(3'd4, d);
    chk("t7_status", 64'(d), 64'h0001_0000);

    repeat (4) tick();
    chk("sb_drain", 64'(sbq.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
